fmul_issue_sched: RTL and testbench
===================================

Name: fmul_issue_sched

Overview:
- Shares one fixed-latency FMUL pipeline between two requesters: the multiplier front-end (special-case detect, sign) plus the downstream stages.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- Operands are issued on registered outputs. Each operation carries a requester tag down a delay line matched to the pipeline depth, so every result is routed back to its owner.
- A flush state machine lets the controller quiesce the multiplier, for example before reconfiguration.

Parameters:
- LATENCY, 4, cycles from op_valid to res_valid in the FMUL pipeline; legal range 1..16.
- CNT_W, 5, in-flight counter width; must hold the value LATENCY+2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nRESET  in  1  reset; one clock, asynchronous and active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  32  requester 0 operand A, IEEE-754 single.
- req0_b  in  32  requester 0 operand B.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- op_valid  out  1  operation launched into FMUL.
- op_a  out  32  operand A to FMUL (sign/exp/frac fields).
- op_b  out  32  operand B to FMUL.
- res_valid  in  1  FMUL result valid.
- res_data  in  32  FMUL result.
- res_error  in  1  FMUL invalid-operation flag.
- rsp0_valid  out  1  one-cycle pulse: result for requester 0.
- rsp1_valid  out  1  one-cycle pulse: result for requester 1.
- rsp_data  out  32  result, shared by both response ports.
- rsp_error  out  1  error flag accompanying rsp_data.
- cfg_flush  in  1  level request to stop issuing and drain.
- flush_done  out  1  high while drained and cfg_flush still high.
- err_mismatch  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs 0; op_a/op_b/rsp_data 0; state RUN; last_grant=1 (requester 0 wins first); tag line cleared; inflight=0.

Arbitration (combinational, in state RUN and cfg_flush=0 only):
- Single valid requester is granted.
- Both valid: grant the requester not equal to last_grant.
- reqN_ready = grant to N; ready may depend on valid.
- Handshake = valid & ready. On a handshake, last_grant <= N.
- At most one ready is high per cycle.

Issue:
- A handshake in cycle T drives op_valid=1 with op_a/op_b registered in T+1.
- With no handshake, op_valid=0 and op_a/op_b hold their values.

Tag line:
- LATENCY-stage shift register of {valid, id}, loaded at op issue (T+1).
- The stage output aligns with res_valid at T+1+LATENCY.

Response:
- Registered. At T+2+LATENCY: rspN_valid=1 for the stored id, rsp_data=res_data, rsp_error=res_error.
- Total latency from handshake to response: LATENCY+2.

Mismatch:
- If res_valid differs from the tag-line output valid, err_mismatch <= 1 (sticky until reset).
- No response pulse in that cycle.

In-flight counter:
- +1 on handshake, -1 on a response pulse; both in the same cycle → unchanged.
- Maximum value LATENCY+2, which is why CNT_W must hold LATENCY+2.

FSM:
- RUN: cfg_flush=1 → DRAIN. No grants in the same cycle; flush has priority over requests.
- DRAIN: no grants. When inflight==0 → DONE.
- DONE: flush_done=1. When cfg_flush=0 → RUN, and flush_done drops in that same cycle.
- If cfg_flush drops during DRAIN, the FSM stays in DRAIN until empty, then passes through DONE for one cycle.

Reset mid-operation:
- In-flight ops are discarded and no responses are produced.
- Any late res_valid from the pipeline within LATENCY cycles after reset is ignored; err_mismatch is masked for LATENCY cycles after reset release, using a counter.

Decomposition:
- Shared package fpu_pkg:
  - EXP_MAX=255, EXP_BIAS=127.
  - FP32 field widths: sign 1, exp 8, frac 23.
  - Requester id type (1 bit).
  - FSM state encoding: RUN, DRAIN, DONE.
- One natural sub-module: fmul_tag_delay, a parameterised LATENCY-deep {valid,id} shift register with synchronous shift and async reset.

Test Plan (LATENCY=4):
- Single op:
  - Stimulus: req0 1.5×2.0, A=0x3FC00000, B=0x40000000; bench pipeline returns 0x40400000.
  - Response: req0_ready in cycle 0; op_valid in cycle 1; rsp0_valid=1 with rsp_data=0x40400000, rsp_error=0 in cycle 6; rsp1_valid stays 0.
- Contention:
  - Stimulus: both requesters hold valid for 4 cycles.
  - Response: grants alternate 0,1,0,1; responses alternate 0,1,0,1 with 6-cycle latency each.
- Error passthrough:
  - Stimulus: req1 with A=0x7F800000 (inf), B=0x00000000; bench asserts res_error.
  - Response: rsp1_valid with rsp_error=1, rsp_data=0x7FC00000.
- Flush:
  - Stimulus: 3 back-to-back ops, then cfg_flush=1 in cycle 3.
  - Response: no ready from cycle 3; flush_done rises in the cycle after the last response; dropping cfg_flush returns to RUN and a new grant is issued in that cycle.
- Mismatch:
  - Stimulus: bench injects res_valid with no op outstanding.
  - Response: err_mismatch=1 and stays set; no rsp pulse.
- Reset mid-flight:
  - Stimulus: assert nRESET asynchronously mid-cycle with 2 ops in flight.
  - Response: all outputs 0 immediately; no rsp after release; err_mismatch stays 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the FMUL issue scheduler: field widths,
// requester tag types and the flush state encoding.
package fpu_pkg;

    localparam int FP_W     = 32;
    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_MAX  = 255;
    localparam int EXP_BIAS = 127;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Requester identifier: 0 or 1.
    typedef logic req_id_t;

    // One stage of the result-routing tag line.
    typedef struct packed {
        logic    vld;
        req_id_t id;
    } tag_t;

    // Flush state machine encoding.
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/fmul_issue_sched_if.sv
// Bundle of requester, FMUL and control signals around the issue scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface fmul_issue_sched_if;
    import fpu_pkg::*;

    logic            req0_valid;
    logic            req0_ready;
    logic [FP_W-1:0] req0_a;
    logic [FP_W-1:0] req0_b;
    logic            req1_valid;
    logic            req1_ready;
    logic [FP_W-1:0] req1_a;
    logic [FP_W-1:0] req1_b;
    logic            op_valid;
    logic [FP_W-1:0] op_a;
    logic [FP_W-1:0] op_b;
    logic            res_valid;
    logic [FP_W-1:0] res_data;
    logic            res_error;
    logic            rsp0_valid;
    logic            rsp1_valid;
    logic [FP_W-1:0] rsp_data;
    logic            rsp_error;
    logic            cfg_flush;
    logic            flush_done;
    logic            err_mismatch;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_valid, res_data, res_error, cfg_flush,
        output req0_ready, req1_ready, op_valid, op_a, op_b,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_error,
        output flush_done, err_mismatch
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_valid, res_data, res_error, cfg_flush,
        input  req0_ready, req1_ready, op_valid, op_a, op_b,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_error,
        input  flush_done, err_mismatch
    );

endinterface

// File: rtl/fmul_tag_delay.sv
// LATENCY-deep shift register of {valid, requester id}; its output lines up
// with the FMUL result so each result can be routed to its owner.
module fmul_tag_delay
    import fpu_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    in_vld,
    input  req_id_t in_id,
    output logic    out_vld,
    output req_id_t out_id
);

    tag_t [LATENCY-1:0] stage_q;
    tag_t [LATENCY-1:0] stage_d;

    // Shift one stage per clock; stage 0 takes the newly issued op.
    always_comb begin
        stage_d[0] = '{vld: in_vld, id: in_id};
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Tag line state; cleared on reset so in-flight ops are forgotten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_vld = stage_q[LATENCY-1].vld;
    assign out_id  = stage_q[LATENCY-1].id;

endmodule

// File: rtl/fmul_issue_sched.sv
// Round-robin issue scheduler sharing one fixed-latency FMUL between two
// requesters, with result routing by tag and a flush/drain state machine.
module fmul_issue_sched
    import fpu_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic nRESET,
    fmul_issue_sched_if.slave bus
);

    localparam int              MASK_W    = $clog2(LATENCY + 1);
    localparam logic [MASK_W-1:0] MASK_INIT = MASK_W'(LATENCY);

    logic [1:0]        state_q, state_d;
    req_id_t           last_grant_q, last_grant_d;
    logic              op_valid_q, op_valid_d;
    logic [FP_W-1:0]   op_a_q, op_a_d;
    logic [FP_W-1:0]   op_b_q, op_b_d;
    req_id_t           op_id_q, op_id_d;
    logic              rsp0_q, rsp0_d;
    logic              rsp1_q, rsp1_d;
    logic [FP_W-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_error_q, rsp_error_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [MASK_W-1:0] mask_q, mask_d;

    logic    grant_en, grant0, grant1, hs;
    logic    tag_vld;
    req_id_t tag_id;
    logic    res_masked, rsp_fire, mismatch, rsp_pulse;

    fmul_tag_delay #(.LATENCY(LATENCY)) u_tag (
        .clk    (clk),
        .rst    (nRESET),
        .in_vld (op_valid_q),
        .in_id  (op_id_q),
        .out_vld(tag_vld),
        .out_id (tag_id)
    );

    // Round-robin grant. Dropping cfg_flush while in DONE already counts as
    // being back in RUN, so a waiting requester is granted in that cycle.
    always_comb begin
        grant_en = !bus.cfg_flush && (state_q == ST_RUN || state_q == ST_DONE);
        grant0   = grant_en && bus.req0_valid && (!bus.req1_valid || last_grant_q == 1'b1);
        grant1   = grant_en && bus.req1_valid && (!bus.req0_valid || last_grant_q == 1'b0);
        hs       = grant0 || grant1;
    end

    // Issue, response routing, mismatch detection and bookkeeping.
    always_comb begin
        res_masked   = (mask_q != '0);
        rsp_fire     = !res_masked && bus.res_valid && tag_vld;
        mismatch     = !res_masked && (bus.res_valid != tag_vld);
        rsp_pulse    = rsp0_q || rsp1_q;

        last_grant_d = hs ? grant1 : last_grant_q;
        op_valid_d   = hs;
        op_id_d      = hs ? grant1 : op_id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        if (grant0) begin
            op_a_d = bus.req0_a;
            op_b_d = bus.req0_b;
        end else if (grant1) begin
            op_a_d = bus.req1_a;
            op_b_d = bus.req1_b;
        end

        rsp0_d      = rsp_fire && (tag_id == 1'b0);
        rsp1_d      = rsp_fire && (tag_id == 1'b1);
        rsp_data_d  = rsp_fire ? bus.res_data : rsp_data_q;
        rsp_error_d = rsp_fire ? bus.res_error : rsp_error_q;
        err_d       = err_q || mismatch;
        mask_d      = res_masked ? mask_q - 1'b1 : mask_q;

        // An op leaves the count when its response pulse is visible.
        case ({hs, rsp_pulse})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // Flush FSM; DRAIN looks at the next count so DONE follows the last pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (bus.cfg_flush) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight_d == '0) state_d = ST_DONE;
            ST_DONE:  if (!bus.cfg_flush) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // All scheduler state; reset clears outputs and arms the result mask.
    always_ff @(posedge clk or posedge nRESET) begin
        if (nRESET) begin
            state_q      <= ST_RUN;
            last_grant_q <= 1'b1;
            op_valid_q   <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= 1'b0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
            err_q        <= 1'b0;
            inflight_q   <= '0;
            mask_q       <= MASK_INIT;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_valid_q   <= op_valid_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
            rsp0_q       <= rsp0_d;
            rsp1_q       <= rsp1_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
            err_q        <= err_d;
            inflight_q   <= inflight_d;
            mask_q       <= mask_d;
        end
    end

    assign bus.req0_ready   = grant0;
    assign bus.req1_ready   = grant1;
    assign bus.op_valid     = op_valid_q;
    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign bus.rsp0_valid   = rsp0_q;
    assign bus.rsp1_valid   = rsp1_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_error    = rsp_error_q;
    assign bus.flush_done   = (state_q == ST_DONE) && bus.cfg_flush;
    assign bus.err_mismatch = err_q;

endmodule

// File: tb/tb_fmul_issue_sched.sv
// Directed bench for fmul_issue_sched with a behavioural 4-cycle FMUL model.
module tb_fmul_issue_sched;
    import fpu_pkg::*;

    localparam int LAT = 4;

    logic clk    = 1'b0;
    logic nRESET = 1'b1;
    always #5 clk = ~clk;

    fmul_issue_sched_if bus();

    fmul_issue_sched #(.LATENCY(LAT), .CNT_W(5)) dut (
        .clk   (clk),
        .nRESET(nRESET),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural FMUL: fixed latency, products for the operands used here.
    logic        mdl_clr   = 1'b1;
    logic        inj_valid = 1'b0;
    logic        pv [LAT];
    logic [31:0] pd [LAT];
    logic        pe [LAT];

    function automatic logic [31:0] fmul_data(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3FC00000_40000000: return 32'h40400000;
            64'h3F800000_40000000: return 32'h40000000;
            64'h40000000_40000000: return 32'h40800000;
            64'h40400000_40000000: return 32'h40C00000;
            64'h7F800000_00000000: return 32'h7FC00000;
            default:               return 32'h00000000;
        endcase
    endfunction

    function automatic logic fmul_err(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'hFF && b[30:0] == 31'd0);
    endfunction

    always @(posedge clk) begin
        if (mdl_clr) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= 32'd0;
                pe[i] <= 1'b0;
            end
        end else begin
            pv[0] <= bus.op_valid;
            pd[0] <= fmul_data(bus.op_a, bus.op_b);
            pe[0] <= fmul_err(bus.op_a, bus.op_b);
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
                pe[i] <= pe[i-1];
            end
        end
    end

    assign bus.res_valid = pv[LAT-1] | inj_valid;
    assign bus.res_data  = inj_valid ? 32'hDEADBEEF : pd[LAT-1];
    assign bus.res_error = pv[LAT-1] & pe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
        bus.cfg_flush  = 1'b0;
        inj_valid      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clk);
        #3 nRESET = 1'b1;
        @(posedge clk);
        #3 nRESET = 1'b0;
        repeat (LAT + 3) @(posedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        nRESET = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus.op_valid !== 1'b0) $display("FAIL reset_op_valid got=%b exp=0", bus.op_valid); else n_pass++;
        n_total++; if (bus.op_a !== 32'd0) $display("FAIL reset_op_a got=%h exp=0", bus.op_a); else n_pass++;
        n_total++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) $display("FAIL reset_rsp got=%b%b exp=00", bus.rsp0_valid, bus.rsp1_valid); else n_pass++;
        n_total++; if (bus.rsp_data !== 32'd0) $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); else n_pass++;
        n_total++; if (bus.err_mismatch !== 1'b0 || bus.flush_done !== 1'b0) $display("FAIL reset_flags got=%b%b exp=00", bus.err_mismatch, bus.flush_done); else n_pass++;
        mdl_clr = 1'b0;
        #3 nRESET = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #1;
        n_total++; if (bus.err_mismatch !== 1'b0 || bus.op_valid !== 1'b0) $display("FAIL reset_idle got=%b%b exp=00", bus.err_mismatch, bus.op_valid); else n_pass++;
    endtask

    task automatic test_single_op();
        for (int c = 0; c < 9; c++) begin
            tick();
            bus.req0_valid = (c == 0);
            bus.req0_a     = 32'h3FC00000;
            bus.req0_b     = 32'h40000000;
            #1;
            if (c == 0) begin
                n_total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) $display("FAIL single_ready c=%0d got=%b%b exp=10", c, bus.req0_ready, bus.req1_ready); else n_pass++;
            end
            if (c == 1) begin
                n_total++; if (bus.op_valid !== 1'b1 || bus.op_a !== 32'h3FC00000 || bus.op_b !== 32'h40000000) $display("FAIL single_issue got=%b %h %h exp=1 3fc00000 40000000", bus.op_valid, bus.op_a, bus.op_b); else n_pass++;
            end
            n_total++; if (bus.rsp0_valid !== (c == 6) || bus.rsp1_valid !== 1'b0) $display("FAIL single_rsp c=%0d got=%b%b exp=%b0", c, bus.rsp0_valid, bus.rsp1_valid, (c == 6)); else n_pass++;
            if (c == 6) begin
                n_total++; if (bus.rsp_data !== 32'h40400000 || bus.rsp_error !== 1'b0) $display("FAIL single_data got=%h %b exp=40400000 0", bus.rsp_data, bus.rsp_error); else n_pass++;
            end
        end
    endtask

    task automatic test_contention();
        logic        e_r0, e_r1, e_s0, e_s1;
        logic [31:0] e_d;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            tick();
            bus.req0_valid = (c < 4);
            bus.req0_a     = (c >= 1) ? 32'h40000000 : 32'h3F800000;
            bus.req0_b     = 32'h40000000;
            bus.req1_valid = (c < 4);
            bus.req1_a     = (c >= 2) ? 32'h40400000 : 32'h40000000;
            bus.req1_b     = 32'h40000000;
            #1;
            e_r0 = (c == 0 || c == 2);
            e_r1 = (c == 1 || c == 3);
            e_s0 = (c == 6 || c == 8);
            e_s1 = (c == 7 || c == 9);
            case (c)
                6:       e_d = 32'h40000000;
                7, 8:    e_d = 32'h40800000;
                9:       e_d = 32'h40C00000;
                default: e_d = 32'h0;
            endcase
            n_total++; if (bus.req0_ready !== e_r0 || bus.req1_ready !== e_r1) $display("FAIL cont_grant c=%0d got=%b%b exp=%b%b", c, bus.req0_ready, bus.req1_ready, e_r0, e_r1); else n_pass++;
            n_total++; if (bus.rsp0_valid !== e_s0 || bus.rsp1_valid !== e_s1) $display("FAIL cont_rsp c=%0d got=%b%b exp=%b%b", c, bus.rsp0_valid, bus.rsp1_valid, e_s0, e_s1); else n_pass++;
            if (e_s0 || e_s1) begin
                n_total++; if (bus.rsp_data !== e_d) $display("FAIL cont_data c=%0d got=%h exp=%h", c, bus.rsp_data, e_d); else n_pass++;
            end
        end
    endtask

    task automatic test_error();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tick();
            bus.req1_valid = (c == 0);
            bus.req1_a     = 32'h7F800000;
            bus.req1_b     = 32'h00000000;
            #1;
            if (c == 0) begin
                n_total++; if (bus.req1_ready !== 1'b1) $display("FAIL err_ready got=%b exp=1", bus.req1_ready); else n_pass++;
            end
            n_total++; if (bus.rsp1_valid !== (c == 6) || bus.rsp0_valid !== 1'b0) $display("FAIL err_rsp c=%0d got=%b%b exp=0%b", c, bus.rsp0_valid, bus.rsp1_valid, (c == 6)); else n_pass++;
            if (c == 6) begin
                n_total++; if (bus.rsp_data !== 32'h7FC00000 || bus.rsp_error !== 1'b1) $display("FAIL err_data got=%h %b exp=7fc00000 1", bus.rsp_data, bus.rsp_error); else n_pass++;
            end
        end
    endtask

    task automatic test_flush();
        logic        e_r0, e_fd, e_s0;
        logic [31:0] e_d;
        do_reset();
        for (int c = 0; c < 19; c++) begin
            tick();
            bus.req0_valid = (c <= 11);
            bus.req0_a     = (c == 0) ? 32'h3F800000 : (c == 1) ? 32'h40000000 : 32'h40400000;
            bus.req0_b     = 32'h40000000;
            bus.cfg_flush  = (c >= 3 && c <= 10);
            #1;
            e_r0 = (c <= 2) || (c == 11);
            e_fd = (c == 9 || c == 10);
            e_s0 = (c == 6 || c == 7 || c == 8 || c == 17);
            case (c)
                6:       e_d = 32'h40000000;
                7:       e_d = 32'h40800000;
                default: e_d = 32'h40C00000;
            endcase
            n_total++; if (bus.req0_ready !== e_r0) $display("FAIL flush_ready c=%0d got=%b exp=%b", c, bus.req0_ready, e_r0); else n_pass++;
            n_total++; if (bus.flush_done !== e_fd) $display("FAIL flush_done c=%0d got=%b exp=%b", c, bus.flush_done, e_fd); else n_pass++;
            n_total++; if (bus.rsp0_valid !== e_s0) $display("FAIL flush_rsp c=%0d got=%b exp=%b", c, bus.rsp0_valid, e_s0); else n_pass++;
            if (e_s0) begin
                n_total++; if (bus.rsp_data !== e_d) $display("FAIL flush_data c=%0d got=%h exp=%h", c, bus.rsp_data, e_d); else n_pass++;
            end
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            tick();
            inj_valid = (c == 0);
            #1;
            n_total++; if (bus.err_mismatch !== (c >= 1)) $display("FAIL mism_err c=%0d got=%b exp=%b", c, bus.err_mismatch, (c >= 1)); else n_pass++;
            n_total++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) $display("FAIL mism_rsp c=%0d got=%b%b exp=00", c, bus.rsp0_valid, bus.rsp1_valid); else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        tick();
        bus.req0_valid = 1'b1; bus.req0_a = 32'h3F800000; bus.req0_b = 32'h40000000;
        #1;
        n_total++; if (bus.req0_ready !== 1'b1) $display("FAIL mid_ready0 got=%b exp=1", bus.req0_ready); else n_pass++;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'h40000000; bus.req1_b = 32'h40000000;
        #1;
        n_total++; if (bus.req1_ready !== 1'b1) $display("FAIL mid_ready1 got=%b exp=1", bus.req1_ready); else n_pass++;
        tick();
        bus.req1_valid = 1'b0;
        #1;
        n_total++; if (bus.op_valid !== 1'b1 || bus.op_a !== 32'h40000000) $display("FAIL mid_issue got=%b %h exp=1 40000000", bus.op_valid, bus.op_a); else n_pass++;
        #2 nRESET = 1'b1;
        #1;
        n_total++; if (bus.op_valid !== 1'b0 || bus.op_a !== 32'd0 || bus.op_b !== 32'd0) $display("FAIL mid_async got=%b %h %h exp=0 0 0", bus.op_valid, bus.op_a, bus.op_b); else n_pass++;
        n_total++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.rsp_data !== 32'd0 || bus.err_mismatch !== 1'b0) $display("FAIL mid_async_rsp got=%b%b %h %b exp=00 0 0", bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, bus.err_mismatch); else n_pass++;
        @(posedge clk);
        #3 nRESET = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_total++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.err_mismatch !== 1'b0) $display("FAIL mid_after c=%0d got=%b%b %b exp=00 0", c, bus.rsp0_valid, bus.rsp1_valid, bus.err_mismatch); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_error();
        test_flush();
        test_mismatch();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
